div_iter: RTL

- Parametrised iterative restoring divider for the RISC5 core's DIV instruction path.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, retiring BPC quotient bits per cycle.
- Holds the pipeline with the existing run/stall convention.
- Adds over the 32-bit fixed divider: width and radix parameters, a reset, a divide-by-zero flag, run-abort, and an optional early exit.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_iter_if.sv | 16 +
 rtl/div_step.sv | 24 ++
 rtl/div_iter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic int clog2(input int value);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < 31; i++) begin
      if (p < value) begin
        r = i + 1;
        p = p * 2;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Core-side run/stall divide bus: operands in, stall and results out.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic             run;
  logic             u;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             stall;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             dz;

  modport master (output run, u, x, y, input stall, quot, rem, dz);
  modport slave  (input run, u, x, y, output stall, quot, rem, dz);
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on the {remainder, quotient} register.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq_i,
  input  logic [WIDTH-1:0]   y_i,
  output logic [2*WIDTH-1:0] rq_o
);

  logic [WIDTH:0] w_s;
  logic           take_s;

  // Trial subtract; the shifted-out top bit is zero in normal use but keeps the step exact.
  always_comb begin
    w_s    = {1'b0, rq_i[2*WIDTH-2:WIDTH-1]} - {1'b0, y_i};
    take_s = rq_i[2*WIDTH-1] | ~w_s[WIDTH];
    if (take_s) begin
      rq_o = {w_s[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b1};
    end else begin
      rq_o = {rq_i[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider (floored signed / unsigned), BPC quotient bits per cycle.
// Optional early exit for |x| < y is enabled by defining DIV_EARLY_EXIT_EN.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);

  localparam int DIV_ITERS = WIDTH / BPC;
  localparam int CW        = clog2(DIV_ITERS);
  // LOAD already retires the first BPC bits, so ITER covers the remaining DIV_ITERS-1 batches.
  localparam logic [CW-1:0]    LAST_CNT = CW'(DIV_ITERS - 2);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  div_state_e         state_q;
  logic [2*WIDTH-1:0] rq_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   y_q;
  logic               sign_q;
  logic               dz_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;

  logic               load_s;
  logic               sign_s;
  logic               cur_sign_s;
  logic               early_s;
  logic [WIDTH-1:0]   x_abs_s;
  logic [WIDTH-1:0]   y_s;
  logic [2*WIDTH-1:0] rq_src_s;
  logic [2*WIDTH-1:0] step_out_s;
  logic [2*WIDTH-1:0] fin_s;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   cq_s;
  logic [WIDTH-1:0]   cr_s;

  // Operand selection: LOAD works straight from the bus, ITER from the latched copies.
  always_comb begin
    load_s  = (state_q == LOAD);
    sign_s  = bus.u & bus.x[WIDTH-1];
    x_abs_s = sign_s ? (~bus.x + ONE_W) : bus.x;
    if (load_s) begin
      rq_src_s   = {ZERO_W, x_abs_s};
      y_s        = bus.y;
      cur_sign_s = sign_s;
    end else begin
      rq_src_s   = rq_q;
      y_s        = y_q;
      cur_sign_s = sign_q;
    end
  end

  for (genvar g = 0; g < BPC; g++) begin : g_step
    logic [2*WIDTH-1:0] in_s;
    logic [2*WIDTH-1:0] out_s;
    if (g == 0) begin : g_first
      assign in_s = rq_src_s;
    end else begin : g_next
      assign in_s = g_step[g-1].out_s;
    end
    div_step #(.WIDTH(WIDTH)) u_step (
      .rq_i (in_s),
      .y_i  (y_s),
      .rq_o (out_s)
    );
  end

  assign step_out_s = g_step[BPC-1].out_s;

  // Final RQ value and floored sign correction of the quotient/remainder pair.
  always_comb begin
    early_s = 1'b0;
`ifdef DIV_EARLY_EXIT_EN
    early_s = load_s && (bus.y != ZERO_W) && (x_abs_s < bus.y);
`endif
    if (early_s) begin
      fin_s = {x_abs_s, ZERO_W};
    end else begin
      fin_s = step_out_s;
    end
    r_s = fin_s[2*WIDTH-1:WIDTH];
    q_s = fin_s[WIDTH-1:0];
    if (!cur_sign_s) begin
      cq_s = q_s;
      cr_s = r_s;
    end else if (r_s == ZERO_W) begin
      cq_s = ~q_s + ONE_W;
      cr_s = ZERO_W;
    end else begin
      cq_s = ~q_s;
      cr_s = y_s - r_s;
    end
  end

  // Controller, iteration counter and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rq_q    <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CW{1'b0}};
      y_q     <= ZERO_W;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= ZERO_W;
      rem_q   <= ZERO_W;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.run) begin
            state_q <= LOAD;
            dz_q    <= 1'b0;
          end
        end
        LOAD: begin
          if (!bus.run) begin
            state_q <= IDLE;
            dz_q    <= 1'b0;
          end else begin
            y_q    <= bus.y;
            sign_q <= sign_s;
            cnt_q  <= {CW{1'b0}};
            if (bus.y == ZERO_W) begin
              dz_q    <= 1'b1;
              quot_q  <= {WIDTH{1'b1}};
              rem_q   <= bus.x;
              rq_q    <= {ZERO_W, x_abs_s};
              state_q <= DONE;
            end else if (early_s) begin
              rq_q    <= fin_s;
              quot_q  <= cq_s;
              rem_q   <= cr_s;
              state_q <= DONE;
            end else begin
              rq_q    <= fin_s;
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          if (!bus.run) begin
            state_q <= IDLE;
            dz_q    <= 1'b0;
          end else begin
            rq_q <= fin_s;
            if (cnt_q == LAST_CNT) begin
              quot_q  <= cq_s;
              rem_q   <= cr_s;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        DONE: begin
          if (!bus.run) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall = bus.run & (state_q != DONE);
  assign bus.quot  = quot_q;
  assign bus.rem   = rem_q;
  assign bus.dz    = dz_q;

endmodule
